// File: rtl/fp_divsqrt_arbiter_if.sv
// Bundle of scheduler, exec-stage, datapath and flush signals around the shared
// FP div/sqrt unit. The arbiter uses the slave modport; its environment drives master.
interface fp_divsqrt_arbiter_if #(
  parameter int NUM_LANES = 2,
  parameter int AL_PTR_W  = 6,
  parameter int DATA_W    = 32
);
  localparam int OW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  // Handshakes: acq_req is a level held until acq_grant pulses for that lane;
  // start_valid is accepted only for the owner lane while reserved; unit_start,
  // unit_abort and unit_done are single-cycle pulses; release_req is honoured
  // only while finished. Flushes take precedence over every other event.
  logic [NUM_LANES-1:0]          acq_req;
  logic [NUM_LANES*AL_PTR_W-1:0] acq_al_ptr;
  logic [NUM_LANES-1:0]          acq_grant;
  logic [NUM_LANES-1:0]          start_valid;
  logic                          start_is_div;
  logic [2:0]                    start_rm;
  logic [DATA_W-1:0]             start_op_a;
  logic [DATA_W-1:0]             start_op_b;
  logic                          unit_start;
  logic                          unit_is_div;
  logic [2:0]                    unit_rm;
  logic [DATA_W-1:0]             unit_op_a;
  logic [DATA_W-1:0]             unit_op_b;
  logic                          unit_abort;
  logic                          unit_done;
  logic [DATA_W-1:0]             unit_result;
  logic [4:0]                    unit_fflags;
  logic                          release_req;
  logic                          flush_valid;
  logic                          flush_all;
  logic [AL_PTR_W-1:0]           flush_head_ptr;
  logic [AL_PTR_W-1:0]           flush_tail_ptr;
  logic                          reserved;
  logic                          finished;
  logic [OW-1:0]                 owner_lane;
  logic [DATA_W-1:0]             result;
  logic [4:0]                    fflags;

  modport slave (
    input  acq_req, acq_al_ptr, start_valid, start_is_div, start_rm, start_op_a,
           start_op_b, unit_done, unit_result, unit_fflags, release_req,
           flush_valid, flush_all, flush_head_ptr, flush_tail_ptr,
    output acq_grant, unit_start, unit_is_div, unit_rm, unit_op_a, unit_op_b,
           unit_abort, reserved, finished, owner_lane, result, fflags
  );

  modport master (
    output acq_req, acq_al_ptr, start_valid, start_is_div, start_rm, start_op_a,
           start_op_b, unit_done, unit_result, unit_fflags, release_req,
           flush_valid, flush_all, flush_head_ptr, flush_tail_ptr,
    input  acq_grant, unit_start, unit_is_div, unit_rm, unit_op_a, unit_op_b,
           unit_abort, reserved, finished, owner_lane, result, fflags
  );
endinterface

// File: rtl/fp_divsqrt_arbiter.sv
// Reservation arbiter for the single iterative FP div/sqrt unit: round-robin
// grant at issue, launch at EX, hold result until retire, abort on owner flush.
module fp_divsqrt_arbiter #(
  parameter int NUM_LANES = 2,
  parameter int AL_PTR_W  = 6,
  parameter int DATA_W    = 32,
  localparam int OW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input logic clk,
  input logic rst,
  fp_divsqrt_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RESV, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [OW-1:0]        rr_q, owner_q, pick;
  logic                 pick_valid;
  logic [AL_PTR_W-1:0]  owner_ptr_q;
  logic                 in_range, owner_flushed;
  logic [NUM_LANES-1:0] grant_q, grant_d;
  logic                 start_q, start_d, abort_q, abort_d;
  logic                 is_div_q;
  logic [2:0]           rm_q;
  logic [DATA_W-1:0]    op_a_q, op_b_q, result_q;
  logic [4:0]           fflags_q;

  function automatic logic [OW-1:0] rr_lane(input logic [OW-1:0] base, input int k);
    return OW'((int'(base) + k) % NUM_LANES);
  endfunction

  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!pick_valid && bus.acq_req[rr_lane(rr_q, k)]) begin
        pick       = rr_lane(rr_q, k);
        pick_valid = 1'b1;
      end
    end
  end

  // Flush window [head, tail) may wrap; head == tail means the whole list.
  always_comb begin
    in_range = 1'b1;
    if (bus.flush_head_ptr < bus.flush_tail_ptr)
      in_range = (owner_ptr_q >= bus.flush_head_ptr) && (owner_ptr_q < bus.flush_tail_ptr);
    else if (bus.flush_head_ptr > bus.flush_tail_ptr)
      in_range = (owner_ptr_q >= bus.flush_head_ptr) || (owner_ptr_q < bus.flush_tail_ptr);
    owner_flushed = bus.flush_all || (bus.flush_valid && in_range);
  end

  always_comb begin
    state_d = state_q;
    grant_d = '0;
    start_d = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d       = RESV;
          grant_d[pick] = 1'b1;
        end
      end
      RESV: begin
        if (owner_flushed) begin
          state_d = IDLE;
        end else if (bus.start_valid[owner_q]) begin
          state_d = BUSY;
          start_d = 1'b1;
        end
      end
      BUSY: begin
        if (owner_flushed) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (bus.unit_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (owner_flushed || bus.release_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      owner_ptr_q <= '0;
      grant_q     <= '0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      is_div_q    <= 1'b0;
      rm_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      fflags_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      abort_q <= abort_d;
      if (state_q == IDLE && pick_valid) begin
        owner_q     <= pick;
        owner_ptr_q <= bus.acq_al_ptr[int'(pick)*AL_PTR_W +: AL_PTR_W];
        rr_q        <= rr_lane(pick, 1);
      end
      if (start_d) begin
        is_div_q <= bus.start_is_div;
        rm_q     <= bus.start_rm;
        op_a_q   <= bus.start_op_a;
        op_b_q   <= bus.start_op_b;
      end
      if (state_q == BUSY && state_d == DONE) begin
        result_q <= bus.unit_result;
        fflags_q <= bus.unit_fflags;
      end
    end
  end

  assign bus.acq_grant   = grant_q;
  assign bus.unit_start  = start_q;
  assign bus.unit_abort  = abort_q;
  assign bus.unit_is_div = is_div_q;
  assign bus.unit_rm     = rm_q;
  assign bus.unit_op_a   = op_a_q;
  assign bus.unit_op_b   = op_b_q;
  assign bus.reserved    = (state_q != IDLE);
  assign bus.finished    = (state_q == DONE);
  assign bus.owner_lane  = owner_q;
  assign bus.result      = result_q;
  assign bus.fflags      = fflags_q;

  // A retire can only target a held result.
  assert property (@(posedge clk) disable iff (rst)
    bus.release_req |-> !(state_q inside {RESV, BUSY}));

endmodule

// File: tb/tb_fp_divsqrt_arbiter.sv
// Bench for fp_divsqrt_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model of the reservation lifecycle.
module tb_fp_divsqrt_arbiter;
  localparam int N  = 2;
  localparam int PW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fp_divsqrt_arbiter_if #(.NUM_LANES(N), .AL_PTR_W(PW), .DATA_W(DW)) bus ();
  fp_divsqrt_arbiter #(.NUM_LANES(N), .AL_PTR_W(PW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // Model: an op owns the unit, may have been launched, may hold a result.
  bit          m_owned, m_launched, m_held;
  int          m_owner, m_rr;
  logic [PW-1:0] m_ptr;
  logic        m_div;
  logic [2:0]  m_rm;
  logic [DW-1:0] m_a, m_b, m_res;
  logic [4:0]  m_ff;
  logic [N-1:0] e_grant;
  bit          e_start, e_abort;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_window(input logic [PW-1:0] p, h, t);
    logic [PW-1:0] dp, dt;
    if (h == t) return 1'b1;
    dp = p - h;
    dt = t - h;
    return dp < dt;
  endfunction

  task automatic model_reset();
    m_owned = 0; m_launched = 0; m_held = 0; m_owner = 0; m_rr = 0; m_ptr = '0;
    m_div = 0; m_rm = '0; m_a = '0; m_b = '0; m_res = '0; m_ff = '0;
    e_grant = '0; e_start = 0; e_abort = 0;
  endtask

  task automatic model_step();
    bit hit;
    hit = m_owned && (bus.flush_all ||
          (bus.flush_valid && in_window(m_ptr, bus.flush_head_ptr, bus.flush_tail_ptr)));
    e_grant = '0; e_start = 0; e_abort = 0;
    if (!m_owned) begin
      for (int k = 0; k < N; k++) begin
        int lane;
        lane = (m_rr + k) % N;
        if (!m_owned && bus.acq_req[lane]) begin
          m_owned = 1; m_launched = 0; m_held = 0;
          m_owner = lane;
          m_ptr = bus.acq_al_ptr[lane*PW +: PW];
          m_rr = (lane + 1) % N;
          e_grant[lane] = 1'b1;
        end
      end
    end else if (hit) begin
      e_abort = m_launched && !m_held;
      m_owned = 0;
    end else if (!m_launched) begin
      if (bus.start_valid[m_owner]) begin
        m_launched = 1; e_start = 1;
        m_div = bus.start_is_div; m_rm = bus.start_rm;
        m_a = bus.start_op_a; m_b = bus.start_op_b;
      end
    end else if (!m_held) begin
      if (bus.unit_done) begin
        m_held = 1; m_res = bus.unit_result; m_ff = bus.unit_fflags;
      end
    end else if (bus.release_req) begin
      m_owned = 0;
    end
  endtask

  task automatic compare_all();
    check("acq_grant", bus.acq_grant, e_grant);
    check("reserved", bus.reserved, m_owned);
    check("finished", bus.finished, m_owned && m_held);
    check("owner_lane", bus.owner_lane, m_owner);
    check("unit_start", bus.unit_start, e_start);
    check("unit_abort", bus.unit_abort, e_abort);
    check("unit_is_div", bus.unit_is_div, m_div);
    check("unit_rm", bus.unit_rm, m_rm);
    check("unit_op_a", bus.unit_op_a, m_a);
    check("unit_op_b", bus.unit_op_b, m_b);
    check("result", bus.result, m_res);
    check("fflags", bus.fflags, m_ff);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    bus.acq_req = '0; bus.acq_al_ptr = '0; bus.start_valid = '0;
    bus.start_is_div = 0; bus.start_rm = '0; bus.start_op_a = '0; bus.start_op_b = '0;
    bus.unit_done = 0; bus.unit_result = '0; bus.unit_fflags = '0;
    bus.release_req = 0; bus.flush_valid = 0; bus.flush_all = 0;
    bus.flush_head_ptr = '0; bus.flush_tail_ptr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic launch(input logic [N-1:0] lanes, input logic [DW-1:0] a, b);
    bus.start_valid = lanes; bus.start_is_div = 1; bus.start_rm = 3'd0;
    bus.start_op_a = a; bus.start_op_b = b;
    tick();
    bus.start_valid = '0;
  endtask

  task automatic finish_op(input logic [DW-1:0] res);
    bus.unit_done = 1; bus.unit_result = res; bus.unit_fflags = 5'h01;
    tick();
    bus.unit_done = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();

    // 1: basic divide round trip on lane 0
    do_reset();
    check("reset_reserved", bus.reserved, 0);
    bus.acq_req = 2'b01;
    tick();
    check("t1_grant", bus.acq_grant, 2'b01);
    bus.acq_req = '0;
    launch(2'b01, 32'h40400000, 32'h40000000);
    check("t1_start", bus.unit_start, 1);
    tick();
    finish_op(32'h3FC00000);
    check("t1_finished", bus.finished, 1);
    check("t1_result", bus.result, 32'h3FC00000);
    bus.release_req = 1;
    tick();
    bus.release_req = 0;
    check("t1_released", bus.reserved, 0);

    // 2: both lanes requesting, grants alternate
    do_reset();
    exp_q = '{0, 1, 0};
    bus.acq_req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick();
      check("t2_owner", bus.owner_lane, exp_q.pop_front());
      launch(2'b11, $urandom, $urandom);
      tick();
      finish_op($urandom);
      bus.release_req = 1;
      tick();
      bus.release_req = 0;
    end
    bus.acq_req = '0;
    tick();

    // 3: flush of BUSY owner aborts; late done ignored
    do_reset();
    bus.acq_req = 2'b01; bus.acq_al_ptr = {6'd0, 6'd5};
    tick();
    bus.acq_req = '0;
    launch(2'b01, 32'h1, 32'h2);
    bus.flush_valid = 1; bus.flush_head_ptr = 6'd4; bus.flush_tail_ptr = 6'd6;
    tick();
    bus.flush_valid = 0;
    check("t3_abort", bus.unit_abort, 1);
    check("t3_idle", bus.reserved, 0);
    finish_op(32'hDEAD);
    check("t3_not_finished", bus.finished, 0);

    // 4: wrapped flush window
    do_reset();
    bus.acq_req = 2'b01; bus.acq_al_ptr = {6'd0, 6'd62};
    tick();
    bus.acq_req = '0;
    bus.flush_valid = 1; bus.flush_head_ptr = 6'd60; bus.flush_tail_ptr = 6'd2;
    tick();
    bus.flush_valid = 0;
    check("t4_wrap_flushed", bus.reserved, 0);
    bus.acq_req = 2'b01; bus.acq_al_ptr = {6'd0, 6'd10};
    tick();
    bus.acq_req = '0;
    bus.flush_valid = 1;
    tick();
    bus.flush_valid = 0;
    check("t4_outside_kept", bus.reserved, 1);
    bus.flush_all = 1;
    tick();
    bus.flush_all = 0;

    // 5: release and flush_all together in DONE
    do_reset();
    bus.acq_req = 2'b01;
    tick();
    bus.acq_req = '0;
    launch(2'b01, 32'h3, 32'h4);
    tick();
    finish_op(32'h5);
    bus.release_req = 1; bus.flush_all = 1;
    tick();
    bus.release_req = 0; bus.flush_all = 0;
    check("t5_no_abort", bus.unit_abort, 0);
    check("t5_idle", bus.reserved, 0);
    bus.acq_req = 2'b10;
    tick();
    bus.acq_req = '0;
    check("t5_grant_lane1", bus.acq_grant, 2'b10);

    // 6: asynchronous reset while BUSY
    tick();
    launch(2'b10, 32'h7, 32'h8);
    tick();
    #2;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #1;
    check("t6_async_reserved", bus.reserved, 0);
    check("t6_async_abort", bus.unit_abort, 0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    bus.acq_req = 2'b01;
    tick();
    bus.acq_req = '0;
    check("t6_regrant", bus.acq_grant, 2'b01);

    // Random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bus.acq_req = ($urandom_range(0, 3) == 0) ? N'($urandom_range(1, 3)) : '0;
      bus.acq_al_ptr = (N*PW)'($urandom);
      bus.start_valid = N'($urandom_range(0, 3));
      if (m_owned && !m_launched && $urandom_range(0, 1) == 1)
        bus.start_valid[m_owner] = 1'b1;
      bus.start_is_div = 1'($urandom);
      bus.start_rm = 3'($urandom_range(0, 4));
      bus.start_op_a = $urandom;
      bus.start_op_b = $urandom;
      bus.unit_done = 0;
      if (m_owned && m_launched && !m_held && !e_start)
        bus.unit_done = ($urandom_range(0, 9) < 3);
      else if (!m_owned)
        bus.unit_done = ($urandom_range(0, 19) == 0);
      bus.unit_result = $urandom;
      bus.unit_fflags = 5'($urandom);
      bus.release_req = m_owned && m_held && ($urandom_range(0, 9) < 4);
      bus.flush_valid = ($urandom_range(0, 9) == 0);
      bus.flush_all = ($urandom_range(0, 29) == 0);
      bus.flush_head_ptr = PW'($urandom);
      bus.flush_tail_ptr = PW'($urandom);
      tick();
    end
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
